// File: rtl/amux_seq_pkg.sv
// amux_seq_pkg: shared types and constants for the analog mux select sequencer.
package amux_seq_pkg;

  // Width of the shared settle / conversion-timeout down-counter
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/amux_seq_timer.sv
// amux_seq_timer: loadable down-counter that stops at zero, with an expiry flag.
module amux_seq_timer
  import amux_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired_c
);

  logic [CNT_W-1:0] cnt;

  // Load has priority over counting; the count holds once it reaches zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired_c = (cnt == '0);

endmodule

// File: rtl/amux_sel_seq.sv
// amux_sel_seq: drives the analog mux select bus, waits for settling, runs one
// ADC conversion per request and returns the tagged result.
// Optional feature macro: AMUX_SCAN_EN (autonomous round-robin channel scan).
module amux_sel_seq
  import amux_seq_pkg::*;
#(
  parameter int unsigned NCH           = 4,
  parameter int unsigned CHW           = $clog2(NCH),
  parameter int unsigned DATA_W        = 10,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned ADC_TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHW-1:0]    req_chan,
  output logic [CHW-1:0]    sel,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CHW-1:0]    rsp_chan,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  input  logic              scan_en,
  input  logic [NCH-1:0]    scan_mask
);

  // Settle load is one less so that SETTLE lasts exactly SETTLE_CYCLES cycles
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(ADC_TIMEOUT);

  state_e              state, state_d;
  logic [CHW-1:0]      sel_d;
  logic                adc_start_d;
  logic                rsp_valid_d;
  logic [CHW-1:0]      rsp_chan_d;
  logic [DATA_W-1:0]   rsp_data_d;
  logic                rsp_err_d;
  logic                tmr_load;
  logic                tmr_en;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_expired_c;

  logic                scan_req;
  logic [CHW-1:0]      scan_chan;
  logic                acc_valid;
  logic [CHW-1:0]      acc_chan;
  logic                acc_bad;

`ifdef AMUX_SCAN_EN
  logic [CHW-1:0] last_scan;
  logic           scan_hit;

  // Next enabled channel after last_scan, wrapping to the lowest enabled one
  always_comb begin
    scan_hit  = 1'b0;
    scan_chan = last_scan;
    for (int c = int'(NCH) - 1; c >= 0; c--) begin
      if (scan_mask[c]) begin
        scan_hit  = 1'b1;
        scan_chan = CHW'(c);
      end
    end
    for (int c = int'(NCH) - 1; c >= 0; c--) begin
      if (scan_mask[c] && (c > int'(last_scan))) begin
        scan_chan = CHW'(c);
      end
    end
  end

  assign scan_req = scan_en & scan_hit;

  // Remember the last self-issued channel; starts at NCH-1 so channel 0 is first
  always_ff @(posedge clk) begin
    if (reset) begin
      last_scan <= CHW'(NCH - 1);
    end else if ((state == IDLE) && !req_valid && scan_req) begin
      last_scan <= scan_chan;
    end
  end
`else
  logic unused_scan;

  assign scan_req    = 1'b0;
  assign scan_chan   = '0;
  assign unused_scan = ^{scan_en, scan_mask};
`endif

  // External requests always win over the scan engine
  assign acc_valid = req_valid | scan_req;
  assign acc_chan  = req_valid ? req_chan : scan_chan;
  assign acc_bad   = (32'(acc_chan) >= NCH);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign tmr_en    = (state == SETTLE) || (state == CONVERT);

  amux_seq_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .en        (tmr_en),
    .load_val  (tmr_val),
    .expired_c (tmr_expired_c)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d     = state;
    sel_d       = sel;
    adc_start_d = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_chan_d  = rsp_chan;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state)
      IDLE: begin
        if (acc_valid) begin
          if (acc_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_chan_d  = acc_chan;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else if (acc_chan == sel) begin
            state_d     = CONVERT;
            adc_start_d = 1'b1;
            tmr_load    = 1'b1;
            tmr_val     = TIMEOUT_LOAD;
          end else begin
            state_d  = SETTLE;
            sel_d    = acc_chan;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (tmr_expired_c) begin
          state_d     = CONVERT;
          adc_start_d = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = TIMEOUT_LOAD;
        end
      end
      CONVERT: begin
        // adc_start marks the first CONVERT cycle, where adc_done is ignored
        if (!adc_start) begin
          if (adc_done) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_chan_d  = sel;
            rsp_data_d  = adc_data;
            rsp_err_d   = 1'b0;
          end else if (tmr_expired_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_chan_d  = sel;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      adc_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_chan  <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      adc_start <= adc_start_d;
      rsp_valid <= rsp_valid_d;
      rsp_chan  <= rsp_chan_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule
